// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the 3x3 keypad scan controller.
// Holds state encoding, geometry constants and column/key decode helpers.
package keypad_scan_ctrl_pkg;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int KEY_W = 4;
    localparam int CIX_W = 2;

    localparam logic [COLS-1:0] COL_NONE = 3'b111;
    localparam logic [ROWS-1:0] ROW_NONE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        PROBE,
        CONFIRM,
        PRESSED
    } state_e;

    // Active-low one-hot drive for a column index.
    function automatic logic [COLS-1:0] col_drive(logic [CIX_W-1:0] idx);
        logic [COLS-1:0] c;
        case (idx)
            2'd0:    c = 3'b110;
            2'd1:    c = 3'b101;
            default: c = 3'b011;
        endcase
        return c;
    endfunction

    function automatic logic [CIX_W-1:0] col_next(logic [CIX_W-1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Lowest-index low row wins when several rows are pulled down.
    function automatic logic [CIX_W-1:0] row_of(logic [ROWS-1:0] pat);
        logic [CIX_W-1:0] r;
        priority case (1'b1)
            !pat[0]: r = 2'd0;
            !pat[1]: r = 2'd1;
            default: r = 2'd2;
        endcase
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] key_index(
        logic [CIX_W-1:0] cidx,
        logic [ROWS-1:0]  pat
    );
        logic [KEY_W-1:0] c;
        logic [KEY_W-1:0] r;
        c = {2'b00, cidx};
        r = {2'b00, row_of(pat)};
        return c * 4'd3 + r;
    endfunction

endpackage

// File: rtl/d_flip_flop.sv
// Generic D flip-flop cell with asynchronous active-low reset.
// Ports: clk, rst_n, d[W-1:0] in; q[W-1:0] out (reset to RST_VAL).
module d_flip_flop #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl_row_sync.sv
// Two-stage synchronizer for the asynchronous, active-low row lines.
// Ports: clk, rst_n, d[W-1:0] (raw rows) in; q[W-1:0] (synced rows) out.
module row_sync
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int W = ROWS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Reset to all-ones so the released keypad is seen right away.
    d_flip_flop #(.W(W), .RST_VAL({W{1'b1}})) u_ff0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (meta)
    );

    d_flip_flop #(.W(W), .RST_VAL({W{1'b1}})) u_ff1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (meta),
        .q     (q)
    );

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 3x3 keypad scanner: column sequencing, press confirm and release confirm.
// Ports: clk, reset (async low), scan_en, row[2:0] in; col[2:0], key_valid, key_code[3:0], key_held out.
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV     = 50000,
    parameter int SETTLE_TICKS   = 2,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_en,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             key_held
);

    localparam int PRE_W = $clog2(SAMPLE_DIV) + 1;
    localparam int SET_W = $clog2(SETTLE_TICKS) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS) + 1;

    logic [ROWS-1:0]  rs;
    state_e           state_q, state_d;
    logic [CIX_W-1:0] col_idx_q, col_idx_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [DEB_W-1:0] stable_q, stable_d;
    logic [DEB_W-1:0] rel_q, rel_d;
    logic [ROWS-1:0]  pat_q, pat_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_held_q, key_held_d;
    logic             key_valid_q, key_valid_d;

    logic             tick;
    logic [SET_W-1:0] settle_inc;
    logic [DEB_W-1:0] stable_inc;
    logic [DEB_W-1:0] rel_inc;

    row_sync #(.W(ROWS)) u_row_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (row),
        .q     (rs)
    );

    // Free-running prescaler, also active while idle.
    assign tick  = (pre_q == PRE_W'(SAMPLE_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    assign settle_inc = settle_q + SET_W'(1);
    assign stable_inc = stable_q + DEB_W'(1);
    assign rel_inc    = rel_q + DEB_W'(1);

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        settle_d    = settle_q;
        stable_d    = stable_q;
        rel_d       = rel_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;

        if (!scan_en) begin
            state_d    = IDLE;
            col_idx_d  = '0;
            settle_d   = '0;
            stable_d   = '0;
            rel_d      = '0;
            pat_d      = ROW_NONE;
            key_held_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = SETTLE;
                    col_idx_d = '0;
                    settle_d  = '0;
                end
                SETTLE: begin
                    if (tick) begin
                        settle_d = settle_inc;
                        if (settle_inc == SET_W'(SETTLE_TICKS)) begin
                            state_d = PROBE;
                        end
                    end
                end
                PROBE: begin
                    if (tick) begin
                        if (rs != ROW_NONE) begin
                            pat_d    = rs;
                            stable_d = DEB_W'(1);
                            state_d  = CONFIRM;
                        end else begin
                            col_idx_d = col_next(col_idx_q);
                            settle_d  = '0;
                            state_d   = SETTLE;
                        end
                    end
                end
                CONFIRM: begin
                    if (tick) begin
                        if (rs == pat_q) begin
                            stable_d = stable_inc;
                            if (stable_inc == DEB_W'(DEBOUNCE_TICKS)) begin
                                state_d     = PRESSED;
                                rel_d       = '0;
                                key_valid_d = 1'b1;
                                key_held_d  = 1'b1;
                                key_code_d  = key_index(col_idx_q, pat_q);
                            end
                        end else begin
                            // Bounce or early release: drop the candidate.
                            stable_d  = '0;
                            col_idx_d = col_next(col_idx_q);
                            settle_d  = '0;
                            state_d   = SETTLE;
                        end
                    end
                end
                PRESSED: begin
                    if (tick) begin
                        if (rs == ROW_NONE) begin
                            rel_d = rel_inc;
                            if (rel_inc == DEB_W'(DEBOUNCE_TICKS)) begin
                                rel_d      = '0;
                                stable_d   = '0;
                                key_held_d = 1'b0;
                                col_idx_d  = col_next(col_idx_q);
                                settle_d   = '0;
                                state_d    = SETTLE;
                            end
                        end else begin
                            rel_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_idx_q   <= '0;
            pre_q       <= '0;
            settle_q    <= '0;
            stable_q    <= '0;
            rel_q       <= '0;
            pat_q       <= ROW_NONE;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            pre_q       <= pre_d;
            settle_q    <= settle_d;
            stable_q    <= stable_d;
            rel_q       <= rel_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col       = (state_q == IDLE) ? COL_NONE : col_drive(col_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with a keypad model and a key-event scoreboard.
// Edge numbers below count rising edges since reset release.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_en;
    logic [2:0] row;
    logic [2:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [8:0] mask;
    int         cyc;
    int         n_checks = 0;
    int         n_fail   = 0;

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    ev_t sb[$];

    keypad_scan_ctrl #(
        .SAMPLE_DIV     (4),
        .SETTLE_TICKS   (2),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_en   (scan_en),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Key (c,r) is mask bit c*3+r; it pulls row r low while column c is driven.
    always_comb begin
        row = 3'b111;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (mask[c*3+r] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int code, input int when);
        ev_t e;
        e.code = code;
        e.cyc  = when;
        sb.push_back(e);
    endtask

    // Monitor: every key_valid must match the oldest expected event.
    always @(negedge clk) begin
        if (reset && key_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_key_valid", key_code, -1);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("key_code", int'(key_code), e.code);
                check("key_valid_edge", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        scan_en = 1'b1;
        mask    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", col, 3'b111);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_key_held", key_held, 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle scan: 110 from edge 1, then 12-clk dwells.
        at(1);   check("scan_c0_start", col, 3'b110);
        at(11);  check("scan_c0_end", col, 3'b110);
        at(12);  check("scan_c1", col, 3'b101);
        at(23);  check("scan_c1_end", col, 3'b101);
        at(24);  check("scan_c2", col, 3'b011);
        at(36);  check("scan_wrap_c0", col, 3'b110);

        // Key 7 (col 2, row 1): probe at 72, event at 80.
        mask = 9'b010000000;
        expect_ev(7, 80);
        at(60);  check("c2_reached", col, 3'b011);
        at(79);  check("held_before_ev", key_held, 0);
        at(80);  check("held_at_ev", key_held, 1);
        at(100); check("col_stays_c2", col, 3'b011);

        // Release with a one-tick glitch: release lands at 124, not 112.
        mask = '0;
        at(108); mask = 9'b010000000;
        at(112); mask = '0;
        at(113); check("held_after_glitch", key_held, 1);
        at(123); check("held_pre_release", key_held, 1);
        check("col_pre_release", col, 3'b011);
        at(124); check("held_released", key_held, 0);
        check("col_after_release", col, 3'b110);

        // One-tick bounce on key 0 during column 0 probe: aborted.
        at(132); mask = 9'b000000001;
        at(136); mask = '0;
        at(139); check("bounce_col0", col, 3'b110);
        at(140); check("bounce_advance", col, 3'b101);

        // Keys 3 and 4 together on column 1: lowest row wins -> 3.
        mask = 9'b000011000;
        expect_ev(3, 160);
        at(161); check("held_multi", key_held, 1);
        at(170); mask = 9'b000111000;
        at(190); check("held_second_key", key_held, 1);
        check("col_second_key", col, 3'b101);

        // One-clk scan_en drop while held.
        scan_en = 1'b0;
        at(191); check("drop_col", col, 3'b111);
        check("drop_held", key_held, 0);
        check("drop_code_kept", key_code, 3);
        scan_en = 1'b1;
        expect_ev(3, 224);
        at(192); check("resume_col0", col, 3'b110);
        at(204); check("resume_col1", col, 3'b101);
        at(224); check("resume_held", key_held, 1);

        // Release, then start confirming key 8 and reset mid-confirm.
        mask = '0;
        at(236); check("rel2_held", key_held, 0);
        check("rel2_col", col, 3'b011);
        mask = 9'b100000000;
        at(249); check("confirm_col", col, 3'b011);
        check("confirm_no_held", key_held, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_col", col, 3'b111);
        check("async_key_valid", key_valid, 0);
        check("async_key_code", key_code, 0);
        check("async_key_held", key_held, 0);
        repeat (2) @(posedge clk);
        #1;
        check("events_all_seen", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 3x3 whack-a-mole keypad. It drives the three column lines one at a time and samples the three active-low row lines. It confirms a press only after the same row pattern has held for a set number of sample ticks, then emits a one-cycle key event with the hole index 0..8. It sits between the keypad pins and the game FSM and replaces free-running per-row debouncing with a sequenced scan/confirm/release cycle.

Parameters:
SAMPLE_DIV, 50000, clk cycles per sample tick (prescaler period); minimum 2.
SETTLE_TICKS, 2, ticks to wait after changing the driven column before probing rows; minimum 1.
DEBOUNCE_TICKS, 4, consecutive matching ticks required to confirm a press or a release; minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
scan_en  input  1  high = scanning enabled; low = keypad idle
row  input  3  keypad row lines, active-low, asynchronous to clk
col  output  3  column drive, active-low one-hot (3'b110 = column 0); 3'b111 = none driven
key_valid  output  1  one-clk pulse when a press is confirmed
key_code  output  4  hole index col_idx*3+row_idx, 0..8; holds its value until the next key_valid
key_held  output  1  high from the key_valid cycle until the release is confirmed

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, col=3'b111, col_idx=0.
  - key_valid=0, key_code=0, key_held=0, prescaler=0, all counters=0.
- row passes through a 2-flop synchronizer. All decisions use the synchronized value rs (2 clk latency).
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. tick=1 for one clk when count==SAMPLE_DIV-1. The prescaler runs freely, including in IDLE.
- All state transitions except those into and out of IDLE occur only on tick.
- IDLE:
  - col=3'b111.
  - On the first clk with scan_en=1: col_idx=0, col=3'b110, settle_cnt=0, go to SETTLE. This transition does not wait for tick.
- SETTLE:
  - On each tick, settle_cnt++.
  - When settle_cnt reaches SETTLE_TICKS, go to PROBE.
- PROBE (on tick):
  - If rs != 3'b111: latch pat=rs, stable_cnt=1, go to CONFIRM.
  - Otherwise advance the column: col_idx wraps 2 -> 0, update col, clear settle_cnt, go to SETTLE.
- CONFIRM (on tick):
  - If rs==pat: stable_cnt++.
  - If stable_cnt reaches DEBOUNCE_TICKS: go to PRESSED. In that same clk, key_valid=1, key_code=col_idx*3+row_idx, key_held=1.
  - If rs!=pat (including a partial or full release): abandon without an event, advance the column, go to SETTLE.
- row_idx is the lowest-index 0 bit of pat. Multiple rows low in one column: lowest row wins. Keys in unscanned columns are invisible until their column is driven.
- PRESSED:
  - Column stays driven.
  - On each tick: if rs==3'b111 then rel_cnt++, else rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_TICKS: key_held=0, advance the column, go to SETTLE.
  - A second key pressed while in PRESSED produces no event. No rollover.
- key_valid is high for exactly one clk per confirmed press, and never twice without a confirmed release in between.
- scan_en=0 in any state: next clk go to IDLE.
  - col=3'b111, key_held=0, key_valid=0. key_code keeps its value.
  - Counters are cleared.
  - A press in progress is discarded. A held key that is still down when scan_en returns produces a new event after the full scan/confirm sequence.
- Asserting reset mid-operation behaves exactly as the reset state above, regardless of the current state.
- Counter widths: sized with $clog2 of the parameter plus 1, so that a terminal value never wraps.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE, SETTLE, PROBE, CONFIRM, PRESSED;
  - ROWS=3, COLS=3, KEY_W=4;
  - COL_NONE=3'b111.
- One natural sub-module: row_sync, a parameterizable-width 2-flop synchronizer built on the existing d_flip_flop cells with active-low reset.
- The FSM, prescaler and counters stay in keypad_scan_ctrl.

Test Plan:
All scenarios use SAMPLE_DIV=4, SETTLE_TICKS=2, DEBOUNCE_TICKS=3.
- Release reset with scan_en=1 and row=3'b111 -> col cycles 110, 101, 011, 110, dwelling 3 ticks (12 clk) per column once aligned. key_valid never asserts.
- Hold row=3'b101 while col=3'b011 -> exactly one key_valid pulse with key_code=7, 2 ticks after PROBE. key_held=1. Scanning stops on col=3'b011.
- Set row=3'b111 after the previous scenario -> key_held falls after 3 ticks and col advances to 3'b110. Glitching rows low for 1 tick during release resets rel_cnt, extending the release by 3 ticks.
- Drive a 1-tick bounce to row=3'b110 during column 0 -> CONFIRM aborts, no key_valid, col advances to 3'b101.
- Hold row=3'b100 on column 1 -> key_code=3 (lowest row wins). A second key pressed during PRESSED produces no extra key_valid.
- Hold a key confirmed, drop scan_en for 1 clk, then raise it -> col=3'b111 and key_held=0 on the next clk. The key re-confirms with a new single key_valid carrying the same key_code. Async reset mid-CONFIRM -> all outputs return to reset values immediately.
